// File: rtl/rr_mux_8x1_if.sv
// Bundle for the 8-to-1 merging mux: eight source lanes in, one tagged beat out.
// The slave modport is the merger's own view; the master modport is the
// surrounding logic that feeds lanes and drains the output.
interface rr_mux_8x1_if #(
  parameter int WIDTH = 8
);
  logic [7:0]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [2:0]         out_sel;
  logic               out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );
endinterface

// File: rtl/rr_mux_8x1.sv
// Round-robin 8-to-1 merging mux. Each accepted beat is tagged with its lane
// index so the far end can demultiplex it. One registered output beat, one
// cycle of latency, full throughput when the downstream never stalls.
module rr_mux_8x1 #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_mux_8x1_if.slave   bus
);

  logic [2:0]       ptr_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [2:0]       out_sel_reg;

  logic [WIDTH-1:0] lane_data [8];
  logic [7:0]       rot_valid;
  logic             grant_found;
  logic [2:0]       grant_off;
  logic [2:0]       grant_idx;
  logic             load_en;
  logic             xfer;
  logic [7:0]       in_ready_next;

  // Lane data slices and the valid vector rotated so that bit 0 is the lane
  // currently holding highest priority.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      assign rot_valid[gi] = bus.in_valid[ptr_reg + 3'(gi)];
    end
  endgenerate

  // First valid lane at or after ptr, found as the lowest set bit of the rotated vector.
  always_comb begin
    grant_found = 1'b0;
    grant_off   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_valid[i]) begin
        grant_found = 1'b1;
        grant_off   = 3'(i);
      end
    end
  end

  assign grant_idx = ptr_reg + grant_off;
  // The output register can take a beat when empty or draining this cycle.
  assign load_en   = ~out_valid_reg | bus.out_ready;
  assign xfer      = grant_found & load_en;

  // Ready goes only to the granted lane; it never looks at data or at other lanes.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ready
      assign in_ready_next[gi] = xfer & (grant_idx == 3'(gi));
    end
  endgenerate

  assign bus.in_ready  = in_ready_next;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sel   = out_sel_reg;

  // Output beat register and priority pointer; a load wins over a drain so
  // back-to-back beats leave no bubble, and ptr only moves on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= 3'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= 3'd0;
    end else if (xfer) begin
      ptr_reg       <= grant_idx + 3'd1;
      out_valid_reg <= 1'b1;
      out_data_reg  <= lane_data[grant_idx];
      out_sel_reg   <= grant_idx;
    end else if (out_valid_reg & bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_8x1.sv
// Directed bench for rr_mux_8x1: stimulus pushes hand-computed {sel,data}
// beats into a queue, a monitor pops and compares each delivered beat.
module tb_rr_mux_8x1;

  logic clk;
  logic rst;
  logic [7:0] lane_d [8];

  int errors = 0;
  int checks = 0;
  logic [10:0] sb [$];

  rr_mux_8x1_if #(.WIDTH(8)) bus ();

  rr_mux_8x1 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 8; k++) bus.in_data[k*8 +: 8] = lane_d[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_base(input logic [7:0] base);
    for (int k = 0; k < 8; k++) lane_d[k] = base + 8'(k);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive a lane pattern, check the combinational ready, and if a grant is
  // expected queue the beat that lane is about to deliver.
  task automatic beat(input logic [7:0] valid, input logic [7:0] exp_ready,
                      input logic [2:0] exp_sel, input logic [7:0] exp_data);
    bus.in_valid = valid;
    #1;
    chk("in_ready", bus.in_ready, exp_ready);
    if (exp_ready != 8'h00) sb.push_back({exp_sel, exp_data});
    cyc();
  endtask

  // Monitor: every beat the downstream accepts must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got sel=%0d data=%0h expected no beat", bus.out_sel, bus.out_data);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        checks++;
        if ({bus.out_sel, bus.out_data} !== e) begin
          errors++;
          $display("FAIL beat: got sel=%0d data=%0h expected sel=%0d data=%0h",
                   bus.out_sel, bus.out_data, e[10:8], e[7:0]);
        end else begin
          $display("beat sel=%0d data=%0h", bus.out_sel, bus.out_data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b0;
    set_base(8'h00);
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sel",   bus.out_sel,   0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_in_ready",  bus.in_ready,  0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single lane 3 after reset; ptr then 4, so lanes 3 and 4 valid grants 4.
    lane_d[3] = 8'hA5;
    bus.out_ready = 1'b1;
    beat(8'h08, 8'h08, 3'd3, 8'hA5);
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_sel",   bus.out_sel,   3);
    chk("t1_out_data",  bus.out_data,  8'hA5);
    beat(8'h18, 8'h10, 3'd4, 8'h04);
    bus.in_valid = 8'h00;
    cyc();

    // Reset to bring ptr back to 0 before the fairness run.
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // All lanes valid for 16 cycles: grants 0..7 twice, no bubbles.
    set_base(8'h20);
    for (int i = 0; i < 16; i++) begin
      beat(8'hFF, 8'(1 << (i % 8)), 3'(i % 8), 8'h20 + 8'(i % 8));
      chk("t2_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 8'h00;
    cyc();

    // Wrap-around: lane 6 leaves ptr=7, then 7 wins, then 0.
    set_base(8'h60);
    beat(8'h40, 8'h40, 3'd6, 8'h66);
    beat(8'h81, 8'h80, 3'd7, 8'h67);
    beat(8'h81, 8'h01, 3'd0, 8'h60);

    // Backpressure with lanes 2 and 6 pending; lane 5 flickers once mid-stall.
    set_base(8'h80);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2) ? 8'h64 : 8'h44;
      #1;
      chk("bp_in_ready",  bus.in_ready,  0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_sel",   bus.out_sel,   0);
      chk("bp_out_data",  bus.out_data,  8'h60);
      cyc();
    end
    bus.out_ready = 1'b1;
    beat(8'h44, 8'h04, 3'd2, 8'h82);
    chk("bp_no_bubble", bus.out_valid, 1);
    chk("bp_sel",       bus.out_sel,   2);
    beat(8'h44, 8'h40, 3'd6, 8'h86);

    // Idle cycles must not rotate priority: ptr stays 7.
    bus.in_valid = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_in_ready", bus.in_ready, 0);
      cyc();
    end
    beat(8'hFF, 8'h80, 3'd7, 8'h87);
    bus.in_valid = 8'h00;
    cyc();

    // Async reset during continuous traffic drops the held beat.
    set_base(8'hC0);
    beat(8'hFF, 8'h01, 3'd0, 8'hC0);
    beat(8'hFF, 8'h02, 3'd1, 8'hC1);
    beat(8'hFF, 8'h04, 3'd2, 8'hC2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_sel",   bus.out_sel,   0);
    chk("arst_out_data",  bus.out_data,  0);
    sb.delete();
    cyc();
    rst = 1'b0;
    beat(8'hFF, 8'h01, 3'd0, 8'hC0);
    chk("arst_first_sel", bus.out_sel, 0);
    bus.in_valid = 8'h00;
    cyc();
    cyc();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending beats expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
